// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: fetch-stage PC register plus IF/ID pipeline register
// for the 5-stage MIPS pipeline.
//
// - After reset the block waits BOOT_CYCLES cycles in BOOT before it fetches.
// - In RUN it requests imem[pc] every cycle.
// - HALT suspends fetching while halt_req is high.
// - The hazard unit drives pc_hold, ifid_hold and ifid_flush.
// - A taken branch redirects pc.
//
// Optional feature: define FETCH_PERF_CNT_EN to build saturating stall and
// flush counters. When it is undefined, stall_cnt and flush_cnt are tied to 0.
//
// Handshake: imem_req is high only in RUN, and imem_addr always equals pc.
// The word on imem_rdata is consumed on a rising edge only when all of these
// hold in that cycle:
//   - imem_ready is 1
//   - pc_hold is 0
//   - branch_taken is 0
//   - halt_req is 0
// A consumed word becomes visible on ifid_* one cycle later.
module fetch_ifid_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_hold,
  input  logic        ifid_hold,
  input  logic        ifid_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [1:0]  fsm_state_o   // debug: 0 = BOOT, 1 = RUN, 2 = HALT
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  boot_cnt_q;
  logic        imem_req_q;
  logic        halted_q;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        in_run;
  logic        fetch_ok;
  logic        redirect;

  assign in_run   = (state_q == ST_RUN);
  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32

  // A returned word is consumed only in RUN and only when nothing else claims
  // the cycle. A taken branch discards the word fetched alongside it.
  assign fetch_ok = in_run && !halt_req && imem_ready && !pc_hold && !branch_taken;

  // Redirects are honoured in RUN and in HALT, but never in BOOT.
  assign redirect = (state_q != ST_BOOT) && branch_taken && !pc_hold;

  // Sequence BOOT -> RUN <-> HALT, with imem_req and halted registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= 4'd0;
      imem_req_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          boot_cnt_q <= boot_cnt_q + 4'd1;
          if (boot_cnt_q == BOOT_LAST) begin
            state_q    <= ST_RUN;
            imem_req_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            state_q    <= ST_HALT;
            imem_req_q <= 1'b0;
            halted_q   <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!halt_req) begin
            state_q    <= ST_RUN;
            imem_req_q <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_BOOT;
          imem_req_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  // Next pc: a redirect wins, then a consumed fetch advances; otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {branch_target[31:2], 2'b00};
    end else if (fetch_ok) begin
      pc_d = pc_plus4;
    end
  end

  // Next IF/ID contents: a flush beats a hold, a hold keeps the contents, a
  // consumed fetch loads the word, and any other cycle loads a bubble.
  always_comb begin
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (ifid_flush) begin
      ifid_pc4_d   = 32'd0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (!ifid_hold) begin
      if (fetch_ok) begin
        ifid_pc4_d   = pc_plus4;
        ifid_instr_d = imem_rdata;
        ifid_valid_d = 1'b1;
      end else begin
        ifid_pc4_d   = 32'd0;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
    end
  end

  // Register pc and the IF/ID fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ifid_pc4_q   <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating performance counters; only a reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (in_run && (pc_hold || !imem_ready) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

  // The hazard unit never freezes pc while a branch is being taken, because
  // that combination would silently lose the redirect.
  assert property (@(posedge clk) disable iff (!rst_n) !(branch_taken && pc_hold));

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign halted      = halted_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Testbench for fetch_ifid_stage.
// - Inputs are driven on the falling edge.
// - A reference model predicts the outputs after the next rising edge and
//   queues that prediction.
// - A monitor samples the outputs 1 ns after each rising edge and compares.
module tb_fetch_ifid_stage;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          BOOT_CYCLES = 2;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          W           = 165;
  localparam int          M_BOOT      = 0;
  localparam int          M_RUN       = 1;
  localparam int          M_HALT      = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        pc_hold, ifid_hold, ifid_flush, branch_taken, halt_req, imem_ready;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, ifid_valid, halted;
  logic [31:0] imem_addr, ifid_pc4, ifid_instr, stall_cnt, flush_cnt;
  logic [1:0]  fsm_state_o;

  fetch_ifid_stage #(
    .RESET_PC(RESET_PC),
    .BOOT_CYCLES(BOOT_CYCLES),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_hold(pc_hold),
    .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .halt_req(halt_req),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .ifid_pc4(ifid_pc4),
    .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid),
    .halted(halted),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .fsm_state_o(fsm_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mode      = M_BOOT;
  int          m_boot_left = BOOT_CYCLES;
  logic [31:0] m_pc        = RESET_PC;
  logic [31:0] m_pc4       = 32'd0;
  logic [31:0] m_instr     = NOP_INSTR;
  logic        m_valid     = 1'b0;
  logic [31:0] m_stall     = 32'd0;
  logic [31:0] m_flush     = 32'd0;

  // Apply one rising edge to the model using the inputs now on the wires,
  // then queue the outputs expected after that edge.
  task automatic model_edge();
    logic        fetch;
    logic        redirect;
    logic [31:0] e_stall;
    logic [31:0] e_flush;
    if (!rst_n) begin
      m_mode      = M_BOOT;
      m_boot_left = BOOT_CYCLES;
      m_pc        = RESET_PC;
      m_pc4       = 32'd0;
      m_instr     = NOP_INSTR;
      m_valid     = 1'b0;
      m_stall     = 32'd0;
      m_flush     = 32'd0;
    end else begin
      fetch    = (m_mode == M_RUN) && !halt_req && imem_ready && !pc_hold && !branch_taken;
      redirect = (m_mode != M_BOOT) && branch_taken && !pc_hold;
      if ((m_mode == M_RUN) && (pc_hold || !imem_ready) && (m_stall != 32'hFFFF_FFFF)) m_stall++;
      if (ifid_flush && (m_flush != 32'hFFFF_FFFF)) m_flush++;
      if (ifid_flush) begin
        m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
      end else if (!ifid_hold) begin
        if (fetch) begin
          m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end else begin
          m_instr = NOP_INSTR; m_pc4 = 32'd0; m_valid = 1'b0;
        end
      end
      if (redirect) m_pc = {branch_target[31:2], 2'b00};
      else if (fetch) m_pc = m_pc + 32'd4;
      case (m_mode)
        M_BOOT: begin
          m_boot_left--;
          if (m_boot_left == 0) m_mode = M_RUN;
        end
        M_RUN:   if (halt_req) m_mode = M_HALT;
        default: if (!halt_req) m_mode = M_RUN;
      endcase
    end
`ifdef FETCH_PERF_CNT_EN
    e_stall = m_stall;
    e_flush = m_flush;
`else
    e_stall = 32'd0;
    e_flush = 32'd0;
`endif
    exp_q.push_back({(m_mode == M_RUN), m_pc, m_pc4, m_instr, m_valid,
                     (m_mode == M_HALT), e_stall, e_flush, 2'(m_mode)});
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("imem_req",   {31'd0, imem_req},   {31'd0, e[164]});
      check("imem_addr",  imem_addr,           e[163:132]);
      check("ifid_pc4",   ifid_pc4,            e[131:100]);
      check("ifid_instr", ifid_instr,          e[99:68]);
      check("ifid_valid", {31'd0, ifid_valid}, {31'd0, e[67]});
      check("halted",     {31'd0, halted},     {31'd0, e[66]});
      check("stall_cnt",  stall_cnt,           e[65:34]);
      check("flush_cnt",  flush_cnt,           e[33:2]);
      check("fsm_state",  {30'd0, fsm_state_o}, {30'd0, e[1:0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    pc_hold       = 1'b0;
    ifid_hold     = 1'b0;
    ifid_flush    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    halt_req      = 1'b0;
    imem_ready    = 1'b1;
  endtask

  // Inputs are already set at this falling edge: drive fresh read data,
  // predict the next rising edge, and move on to the next falling edge.
  task automatic tick();
    imem_rdata = $urandom();
    model_edge();
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    pc_hold       = ($urandom_range(0, 99) < 15);
    ifid_hold     = ($urandom_range(0, 99) < 15);
    ifid_flush    = ($urandom_range(0, 99) < 10);
    branch_taken  = !pc_hold && ($urandom_range(0, 99) < 12);
    branch_target = $urandom();
    halt_req      = halt_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
    imem_ready    = ($urandom_range(0, 99) < 75);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    imem_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Two boot cycles, then fetch addresses 0 and 4 so that pc reaches 8.
    repeat (4) tick();

    // Freeze pc and IF/ID for one cycle at pc=8, then resume fetching at 8.
    pc_hold = 1'b1; ifid_hold = 1'b1;
    tick();
    idle();
    tick();

    // Flush together with a taken branch to 0x40; the next fetch is from 0x40.
    ifid_flush = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0040;
    tick();
    idle();
    tick();

    // Redirect to the top word (low bits masked), fetch it, and wrap to 0.
    ifid_flush = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    tick();
    idle();
    tick();
    tick();

    // Memory wait for three cycles.
    imem_ready = 1'b0;
    repeat (3) tick();
    idle();
    tick();

    // Halt for four cycles, then assert reset in the middle of HALT.
    halt_req = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_halted",   {31'd0, halted},      32'd0);
    check("async_rst_imem_req", {31'd0, imem_req},    32'd0);
    check("async_rst_pc",       imem_addr,            RESET_PC);
    check("async_rst_valid",    {31'd0, ifid_valid},  32'd0);
    check("async_rst_state",    {30'd0, fsm_state_o}, 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    repeat (4) tick();

    // Random traffic, with an occasional reset.
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
      rst_n = 1'b1;
    end
    idle();
    repeat (3) tick();

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
